// File: rtl/key_debounce.sv
// Purpose: N-channel push-button front end (sync, debounce, press/release strobes, toggle, auto-repeat).
// Latency: a clean pin change sampled at edge k is accepted at edge k+DEBOUNCE_CYC+1; strobes are registered.
// Backpressure: none; the block is free-running and every output is a level or a 1-cycle strobe.
module key_debounce #(
  parameter int N_KEYS         = 2,
  parameter int DEBOUNCE_CYC   = 16,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter bit REPEAT_EN      = 1'b0,
  parameter int HOLD_CYC       = 1000,
  parameter int REPEAT_CYC     = 200
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [N_KEYS-1:0] in_key,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_KEYS-1:0] o_key_press,
  output logic [N_KEYS-1:0] o_key_release,
  output logic [N_KEYS-1:0] o_key_toggle,
  output logic [N_KEYS-1:0] o_key_repeat,
  output logic              o_any_press
);

  // Debounce counter only ever needs to reach DEBOUNCE_CYC-1.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // XOR mask that turns every pin into "1 = pressed".
  localparam logic [N_KEYS-1:0] POL_MASK = {N_KEYS{KEY_ACTIVE_LOW}};

  // Per-channel auto-repeat sequencer states.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Two-stage synchroniser on the normalised pins. Reset loads the
  // released level (0 after normalisation) so a key held through reset
  // still has to refill the synchroniser before it can be accepted.
  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] sync_2;

  // Metastability guard: pins are asynchronous to in_clk.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= in_key ^ POL_MASK;
      sync_2 <= sync_1;
    end
  end

  genvar g;
  for (g = 0; g < N_KEYS; g++) begin : g_ch

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;
    logic             toggle;
    logic             rpt;
    logic             accept;
    logic             accept_press;
    logic             accept_rel;

    assign s = sync_2[g];

    // A change is accepted on the edge where the synchronised value has
    // disagreed with the debounced level for DEBOUNCE_CYC samples in a row.
    assign accept       = (s != level) && (cnt == CNT_LAST);
    assign accept_press = accept &  s;
    assign accept_rel   = accept & ~s;

    // Debounce counter, accepted level, edge strobes and press toggle.
    always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
        cnt    <= '0;
        level  <= 1'b0;
        press  <= 1'b0;
        rel    <= 1'b0;
        toggle <= 1'b0;
      end else begin
        // Strobes rise on the same edge as the level they announce.
        press <= accept_press;
        rel   <= accept_rel;
        if (s == level) begin
          // Any agreeing sample is treated as bounce and restarts the count.
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= s;
          cnt   <= '0;
          if (s) begin
            toggle <= ~toggle;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    if (REPEAT_EN) begin : g_rpt

      // Repeat counter is shared between the hold and repeat phases.
      localparam int               RC_MAX    = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
      localparam int               RC_W      = $clog2(RC_MAX + 1);
      localparam logic [RC_W-1:0]  HOLD_LAST = RC_W'(HOLD_CYC - 1);
      localparam logic [RC_W-1:0]  REP_LAST  = RC_W'(REPEAT_CYC - 1);

      rpt_state_t      state;
      rpt_state_t      state_nxt;
      logic [RC_W-1:0] rc;
      logic [RC_W-1:0] rc_nxt;
      logic            rpt_nxt;

      // Repeat sequencer state, counter and registered strobe.
      always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
          state <= RPT_IDLE;
          rc    <= '0;
          rpt   <= 1'b0;
        end else begin
          state <= state_nxt;
          rc    <= rc_nxt;
          rpt   <= rpt_nxt;
        end
      end

      // Next state: hold timer after a press, then periodic strobes until release.
      always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        rpt_nxt   = 1'b0;
        if (accept_rel) begin
          // Release wins over any strobe that would have fired this cycle.
          state_nxt = RPT_IDLE;
          rc_nxt    = '0;
        end else begin
          case (state)
            RPT_IDLE: begin
              if (accept_press) begin
                state_nxt = RPT_HOLD;
                rc_nxt    = '0;
              end
            end
            RPT_HOLD: begin
              if (rc == HOLD_LAST) begin
                rpt_nxt   = 1'b1;
                rc_nxt    = '0;
                state_nxt = RPT_REPEAT;
              end else begin
                rc_nxt = rc + RC_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rc == REP_LAST) begin
                rpt_nxt = 1'b1;
                rc_nxt  = '0;
              end else begin
                rc_nxt = rc + RC_W'(1);
              end
            end
            default: begin
              state_nxt = RPT_IDLE;
              rc_nxt    = '0;
            end
          endcase
        end
      end

    end else begin : g_no_rpt

      assign rpt = 1'b0;

    end

    assign o_key_level[g]   = level;
    assign o_key_press[g]   = press;
    assign o_key_release[g] = rel;
    assign o_key_toggle[g]  = toggle;
    assign o_key_repeat[g]  = rpt;

  end

  // Any-press is a plain OR of the registered strobes, so it lines up with them.
  assign o_any_press = |o_key_press;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: random and directed pin activity against a window-based reference model.
// Expected strobe events go into a scoreboard queue; a negedge monitor pops them when the DUT strobes.
// Level and toggle are compared every cycle; reset is checked to clear everything immediately.
module tb_key_debounce;

  localparam int N       = 2;
  localparam int D       = 16;
  localparam bit ACT_LOW = 1'b1;
  localparam int H       = 20;
  localparam int R       = 8;
  localparam int MAXC    = 16384;

  logic         in_clk;
  logic         in_rst;
  logic [N-1:0] in_key;
  logic [N-1:0] o_key_level;
  logic [N-1:0] o_key_press;
  logic [N-1:0] o_key_release;
  logic [N-1:0] o_key_toggle;
  logic [N-1:0] o_key_repeat;
  logic         o_any_press;

  key_debounce #(
    .N_KEYS(N), .DEBOUNCE_CYC(D), .KEY_ACTIVE_LOW(ACT_LOW),
    .REPEAT_EN(1'b1), .HOLD_CYC(H), .REPEAT_CYC(R)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_key(in_key),
    .o_key_level(o_key_level), .o_key_press(o_key_press),
    .o_key_release(o_key_release), .o_key_toggle(o_key_toggle),
    .o_key_repeat(o_key_repeat), .o_any_press(o_any_press)
  );

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } evt_t;

  evt_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int unsigned  cyc = 0;
  logic [N-1:0] pin_at [0:MAXC-1];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_toggle = '0;
  int unsigned  last_evt [N];
  int unsigned  press_at [N];

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  // Reference model: a level flips at edge e when the last D synchronised
  // samples (pin captured at edges e-2 .. e-D-1) all disagree with it and
  // no flip/reset happened within that window. Repeats are pure arithmetic
  // on the time since the accepted press.
  initial begin
    logic [N-1:0] ep, er, ert;
    bit flip;
    forever begin
      @(posedge in_clk);
      cyc++;
      ep = '0; er = '0; ert = '0;
      if (!in_rst) begin
        pin_at[cyc] = '0;
        m_level     = '0;
        m_toggle    = '0;
        for (int i = 0; i < N; i++) last_evt[i] = cyc;
      end else begin
        pin_at[cyc] = ACT_LOW ? ~in_key : in_key;
        for (int i = 0; i < N; i++) begin
          flip = 1'b0;
          if (cyc >= last_evt[i] + D) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++)
              if (pin_at[cyc-2-j][i] == m_level[i]) flip = 1'b0;
          end
          if (flip) begin
            if (!m_level[i]) begin
              ep[i]       = 1'b1;
              m_toggle[i] = ~m_toggle[i];
              press_at[i] = cyc;
            end else begin
              er[i] = 1'b1;
            end
            m_level[i]  = ~m_level[i];
            last_evt[i] = cyc;
          end else if (m_level[i] && (cyc - press_at[i] >= H) &&
                       ((cyc - press_at[i] - H) % R == 0)) begin
            ert[i] = 1'b1;
          end
        end
        if (|{ep, er, ert}) sb.push_back('{cyc, ep, er, ert});
      end
    end
  end

  // Monitor: compares away from the active edge.
  initial begin
    evt_t e;
    forever begin
      @(negedge in_clk);
      if (!in_rst) begin
        chk("rst_level",   32'(o_key_level),   32'd0);
        chk("rst_press",   32'(o_key_press),   32'd0);
        chk("rst_release", 32'(o_key_release), 32'd0);
        chk("rst_toggle",  32'(o_key_toggle),  32'd0);
        chk("rst_repeat",  32'(o_key_repeat),  32'd0);
        chk("rst_any",     32'(o_any_press),   32'd0);
      end else begin
        chk("level",  32'(o_key_level),  32'(m_level));
        chk("toggle", 32'(o_key_toggle), 32'(m_toggle));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          chk("missed_event_cycle", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
        if (|{o_key_press, o_key_release, o_key_repeat}) begin
          if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'({o_key_press, o_key_release, o_key_repeat}), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("event_cycle",   cyc, e.cyc);
            chk("event_press",   32'(o_key_press),   32'(e.press));
            chk("event_release", 32'(o_key_release), 32'(e.rel));
            chk("event_repeat",  32'(o_key_repeat),  32'(e.rpt));
            chk("event_any",     32'(o_any_press),   32'(|e.press));
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    in_rst = 1'b0;
    in_key = '1;
    tick(5);
    in_rst = 1'b1;
    tick(100);

    // Clean press and release on key 0 (held long enough to repeat).
    in_key[0] = 1'b0; tick(60);
    in_key[0] = 1'b1; tick(40);

    // Bounce on key 1: 5-cycle pulses, then a solid press.
    for (int b = 0; b < 12; b++) begin
      in_key[1] = ~in_key[1];
      tick(5);
    end
    in_key[1] = 1'b0; tick(60);
    in_key[1] = 1'b1; tick(40);

    // Two press/release pairs on key 0.
    repeat (2) begin
      in_key[0] = 1'b0; tick(50);
      in_key[0] = 1'b1; tick(50);
    end

    // Long hold for a full repeat train, then a release mid-train.
    in_key[0] = 1'b0; tick(117);
    in_key[0] = 1'b1; tick(40);
    in_key[0] = 1'b0; tick(77);
    in_key[0] = 1'b1; tick(40);

    // Both keys accepted on the same edge.
    in_key = '0; tick(40);
    in_key = '1; tick(40);

    // Reset mid-debounce with the key held through reset.
    in_key[0] = 1'b0; tick(12);
    in_rst = 1'b0;
    #1;
    chk("rst_async_level", 32'(o_key_level), 32'd0);
    tick(3);
    in_rst = 1'b1; tick(40);
    in_key[0] = 1'b1; tick(40);

    // Reset mid-repeat.
    in_key[0] = 1'b0; tick(45);
    in_rst = 1'b0;
    #1;
    chk("rst_async_repeat_toggle", 32'(o_key_toggle), 32'd0);
    tick(2);
    in_key[0] = 1'b1;
    in_rst = 1'b1; tick(40);

    // Random pin activity.
    for (int k = 0; k < 150; k++) begin
      in_key = N'($urandom);
      tick($urandom_range(1, 40));
    end
    in_key = '1;
    tick(60);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Parametrised successor to the two-key front-end driver. Handles N_KEYS independent push-buttons.
- Each channel gets:
  - 2-FF synchroniser and polarity normalisation.
  - Counter-based debounce.
  - Registered press/release strobes, a press-toggled "switch" output, and optional auto-repeat while held.
- Sits between board key pins and tester control logic (mode switch, soft reset, stepping).

Parameters:
N_KEYS, 2, number of independent key channels (>=1)
DEBOUNCE_CYC, 16, consecutive stable clocks required to accept a level change (>=1)
KEY_ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
REPEAT_EN, 0, 1 enables o_key_repeat generation
HOLD_CYC, 1000, clocks from accepted press to first repeat strobe (>=1)
REPEAT_CYC, 200, clocks between subsequent repeat strobes (>=1)

Ports:
in_clk  in  1  system clock
in_rst  in  1  asynchronous active-low reset
in_key  in  N_KEYS  raw key pins, asynchronous to in_clk
o_key_level  out  N_KEYS  debounced state, 1 = pressed
o_key_press  out  N_KEYS  1-cycle strobe on accepted press
o_key_release  out  N_KEYS  1-cycle strobe on accepted release
o_key_toggle  out  N_KEYS  inverts on every accepted press
o_key_repeat  out  N_KEYS  1-cycle auto-repeat strobe (tied 0 when REPEAT_EN=0)
o_any_press  out  1  OR of o_key_press, same cycle

Behaviour:
- Reset (in_rst=0, async):
  - Sync FFs load the released level.
  - Stable state = 0; all counters = 0.
  - All outputs = 0.
- Per channel, fully independent; no cross-channel interaction.
- Normalise: n = in_key[i] XOR KEY_ACTIVE_LOW, so 1 = pressed.
- n passes through 2 FFs to give s.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYC+1):
  - If s == o_key_level: cnt <= 0.
  - If s != o_key_level and cnt < DEBOUNCE_CYC-1: cnt++.
  - If s != o_key_level and cnt == DEBOUNCE_CYC-1: o_key_level <= s, cnt <= 0.
- Latency: pin change first sampled at edge k → o_key_level flips at edge k+DEBOUNCE_CYC+1, provided the pin stays constant throughout.
- Glitch: any sample with s == level before the threshold clears cnt; the change is not accepted. Pulse shorter than DEBOUNCE_CYC clocks gives no output activity.
- o_key_press / o_key_release:
  - Registered; high for exactly one cycle, asserted at the same edge o_key_level rises / falls.
  - Never high in the same cycle.
- o_key_toggle flips at the same edge o_key_press asserts.
- Auto-repeat (REPEAT_EN=1):
  - States: IDLE, HOLD, REPEAT. Counter rc width $clog2(max(HOLD_CYC,REPEAT_CYC)+1).
  - IDLE→HOLD on press edge, rc <= 0.
  - HOLD: rc++ each cycle. When rc == HOLD_CYC-1: o_key_repeat=1 for 1 cycle, rc <= 0, go to REPEAT.
  - REPEAT: rc++. When rc == REPEAT_CYC-1: strobe, rc <= 0.
  - Release edge in any state: go to IDLE, rc <= 0, no strobe that cycle.
  - First repeat strobe occurs HOLD_CYC clocks after the o_key_press strobe; later strobes every REPEAT_CYC clocks.
  - o_key_repeat never coincides with o_key_press or o_key_release.
- Key held through reset: after in_rst deasserts, the press is accepted DEBOUNCE_CYC+2 edges later (sync refill + debounce), with normal press strobe and toggle.
- Reset asserted mid-debounce or mid-repeat: immediate clear; no strobe emitted.
- Multiple keys accepted in the same cycle: each raises its own strobe; o_any_press = 1 for that single cycle.

Test Plan:
- Reset + idle: in_rst low 5 cycles, KEY_ACTIVE_LOW=1, in_key=2'b11 → all outputs 0; stay 0 for 100 cycles after release.
- Clean press, DEBOUNCE_CYC=16: drive in_key[0]=0 before edge k → o_key_level[0]=1 and o_key_press[0]=1 at edge k+17. Press is 1 cycle wide; o_key_toggle[0] 0→1; o_any_press=1 same cycle.
- Bounce: in_key[1] toggles every 5 cycles for 60 cycles, then holds low → no strobe during bouncing; single press 17 edges after the last transition.
- Release and toggle: press/release key0 twice, each hold 50 cycles → two press and two release strobes; o_key_toggle[0] sequence 0→1→0.
- Auto-repeat, REPEAT_EN=1, HOLD_CYC=20, REPEAT_CYC=8: hold key0 100 cycles after press → repeat strobes at press+20, +28, +36 … +92. Releasing at press+60 stops strobes; no strobe on the release cycle.
- Reset mid-debounce: assert in_rst at cnt=10 with key held → outputs 0 immediately. After deassert, press accepted at DEBOUNCE_CYC+2 edges.
